// File: rtl/players_ctrl_if.sv
// players_ctrl_if: frame sync, push-buttons and paddle positions between the timing/input side and players_ctrl.
// With PLAYERS_AI_EN defined the bundle also carries ball_y for the player 2 tracker.
interface players_ctrl_if;
    logic       vsync;
    logic       btn_up1;
    logic       btn_dn1;
    logic       btn_up2;
    logic       btn_dn2;
    logic [9:0] pos_ply1;
    logic [9:0] pos_ply2;
`ifdef PLAYERS_AI_EN
    logic [9:0] ball_y;

    modport master (
        output vsync, btn_up1, btn_dn1, btn_up2, btn_dn2, ball_y,
        input  pos_ply1, pos_ply2
    );
    modport slave (
        input  vsync, btn_up1, btn_dn1, btn_up2, btn_dn2, ball_y,
        output pos_ply1, pos_ply2
    );
`else
    modport master (
        output vsync, btn_up1, btn_dn1, btn_up2, btn_dn2,
        input  pos_ply1, pos_ply2
    );
    modport slave (
        input  vsync, btn_up1, btn_dn1, btn_up2, btn_dn2,
        output pos_ply1, pos_ply2
    );
`endif
endinterface

// File: rtl/players_ctrl.sv
// players_ctrl: synchronised, debounced buttons move two paddles once per frame (vsync rise), with acceleration and clamping.
// Optional PLAYERS_AI_EN: player 2 ignores its buttons and tracks ball_y - 30 at STEP_SLOW per frame.
module players_ctrl #(
    parameter int POS_INIT    = 200,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 420,
    parameter int STEP_SLOW   = 2,
    parameter int STEP_FAST   = 6,
    parameter int HOLD_FRAMES = 8,
    parameter int DEB_BITS    = 16
) (
    input  logic          px_clk,
    input  logic          reset,
    players_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_SLOW = 2'd1,
        MOVE_FAST = 2'd2
    } state_t;

    localparam logic signed [10:0] MIN_S    = 11'(POS_MIN);
    localparam logic signed [10:0] MAX_S    = 11'(POS_MAX);
    localparam logic signed [10:0] SLOW_S   = 11'(STEP_SLOW);
    localparam logic signed [10:0] FAST_S   = 11'(STEP_FAST);
    localparam logic [7:0]         HOLD_LIM = 8'(HOLD_FRAMES);
    localparam logic [9:0]         INIT_P   = 10'(POS_INIT);

    // Button bit order: {dn2, up2, dn1, up1}
    logic [3:0] btn_raw;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] btn_deb;
    logic       vs1_q, vs1_d;
    logic       vs2_q, vs2_d;
    logic       tick;

    assign btn_raw = {bus.btn_dn2, bus.btn_up2, bus.btn_dn1, bus.btn_up1};

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        vs1_d   = bus.vsync;
        vs2_d   = vs1_q;
    end

    // vsync history resets high so releasing reset with vsync high cannot fake a frame tick.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vs1_q   <= 1'b1;
            vs2_q   <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
        end
    end

    assign tick = vs1_q & ~vs2_q;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_deb
        logic [DEB_BITS-1:0] cnt_q, cnt_d;
        logic                stable_q, stable_d;

        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            if (sync2_q[gi] == stable_q) begin
                cnt_d = '0;
            end else if (&cnt_q) begin
                stable_d = sync2_q[gi];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge px_clk or posedge reset) begin
            if (reset) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                stable_q <= stable_d;
            end
        end

        assign btn_deb[gi] = stable_q;
    end

    logic [1:0][9:0] pos_all;

    for (gi = 0; gi < 2; gi++) begin : g_ply
        state_t             state_q, state_d;
        logic [7:0]         hold_q, hold_d;
        logic [1:0]         dir;                     // {up, dn}, one-hot or zero
        logic [1:0]         last_dir_q, last_dir_d;
        logic               reversal;
        logic [9:0]         pos_q, pos_d;
        logic signed [10:0] pos_ext, step, moved;
`ifdef PLAYERS_AI_EN
        localparam bit BTN_EN = (gi == 0);
        logic signed [11:0] target, diff;
`else
        localparam bit BTN_EN = 1'b1;
`endif

        assign dir = (BTN_EN && (btn_deb[2*gi] ^ btn_deb[2*gi+1]))
                   ? {btn_deb[2*gi], btn_deb[2*gi+1]} : 2'b00;
        assign reversal = (dir != 2'b00) && (last_dir_q != 2'b00) && (dir != last_dir_q);

        always_ff @(posedge px_clk or posedge reset) begin
            if (reset) begin
                state_q    <= IDLE;
                hold_q     <= '0;
                last_dir_q <= 2'b00;
                pos_q      <= INIT_P;
            end else begin
                state_q    <= state_d;
                hold_q     <= hold_d;
                last_dir_q <= last_dir_d;
                pos_q      <= pos_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            hold_d     = hold_q;
            last_dir_d = last_dir_q;
            if (tick) begin
                last_dir_d = dir;
                if (dir == 2'b00) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (state_q == IDLE || reversal) begin
                    hold_d  = 8'd1;
                    state_d = (hold_d == HOLD_LIM) ? MOVE_FAST : MOVE_SLOW;
                end else if (state_q == MOVE_SLOW) begin
                    hold_d = hold_q + 8'd1;
                    if (hold_d == HOLD_LIM) begin
                        state_d = MOVE_FAST;
                    end
                end
            end
        end

        // A reversal always restarts at the slow step, even out of MOVE_FAST.
        always_comb begin
            pos_ext = $signed({1'b0, pos_q});
            step    = (state_q == MOVE_FAST && !reversal) ? FAST_S : SLOW_S;
            moved   = pos_ext;
            pos_d   = pos_q;
`ifdef PLAYERS_AI_EN
            target  = $signed({2'b00, bus.ball_y}) - 12'sd30;
            diff    = target - $signed({2'b00, pos_q});
`endif
            if (tick) begin
                if (dir == 2'b10) begin
                    moved = pos_ext - step;
                    pos_d = (moved < MIN_S) ? MIN_S[9:0] : moved[9:0];
                end else if (dir == 2'b01) begin
                    moved = pos_ext + step;
                    pos_d = (moved > MAX_S) ? MAX_S[9:0] : moved[9:0];
                end
`ifdef PLAYERS_AI_EN
                if (!BTN_EN) begin
                    if (diff > 12'(SLOW_S)) begin
                        moved = pos_ext + SLOW_S;
                        pos_d = (moved > MAX_S) ? MAX_S[9:0] : moved[9:0];
                    end else if (diff < -12'(SLOW_S)) begin
                        moved = pos_ext - SLOW_S;
                        pos_d = (moved < MIN_S) ? MIN_S[9:0] : moved[9:0];
                    end
                end
`endif
            end
        end

        assign pos_all[gi] = pos_q;
    end

    assign bus.pos_ply1 = pos_all[0];
    assign bus.pos_ply2 = pos_all[1];

endmodule

// File: tb/tb_players_ctrl.sv
// tb_players_ctrl: directed vector table plus clamp, glitch and async-reset sequences for players_ctrl (DEB_BITS=3).
module tb_players_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    players_ctrl_if bus();

    players_ctrl #(.DEB_BITS(3)) dut (
        .px_clk (clk),
        .reset  (rst),
        .bus    (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // btn order: {dn2, up2, dn1, up1}; expectations are cumulative down the table
    typedef struct {
        string      name;
        logic [3:0] btn;
        int         ticks;
        logic [9:0] e1;
        logic [9:0] e2;
    } vec_t;
    vec_t vecs [11];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic set_btn(input logic [3:0] b);
        {bus.btn_dn2, bus.btn_up2, bus.btn_dn1, bus.btn_up1} = b;
        cyc(14);
    endtask

    task automatic frame();
        bus.vsync = 1'b1;
        cyc(4);
        bus.vsync = 1'b0;
        cyc(4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        vecs[0]  = '{"idle_3_ticks",      4'b0000, 3, 10'd200, 10'd200};
        vecs[1]  = '{"dn1_8_slow",        4'b0010, 8, 10'd216, 10'd200};
        vecs[2]  = '{"dn1_2_fast",        4'b0010, 2, 10'd228, 10'd200};
        vecs[3]  = '{"release_frozen",    4'b0000, 2, 10'd228, 10'd200};
        vecs[4]  = '{"dn1_restart_slow",  4'b0010, 1, 10'd230, 10'd200};
        vecs[5]  = '{"both1_hold",        4'b0011, 2, 10'd230, 10'd200};
        vecs[6]  = '{"up2_8slow_1fast",   4'b0100, 9, 10'd230, 10'd178};
        vecs[7]  = '{"dn2_reversal_slow", 4'b1000, 1, 10'd230, 10'd180};
        vecs[8]  = '{"dn2_7_slow",        4'b1000, 7, 10'd230, 10'd194};
        vecs[9]  = '{"dn2_fast",          4'b1000, 1, 10'd230, 10'd200};
        vecs[10] = '{"up1_dn2_together",  4'b1001, 2, 10'd226, 10'd212};

        rst = 1'b1;
        bus.vsync = 1'b0;
        {bus.btn_dn2, bus.btn_up2, bus.btn_dn1, bus.btn_up1} = 4'b0000;
`ifdef PLAYERS_AI_EN
        bus.ball_y = 10'd0;
`endif
        cyc(3);
        check("reset_p1", bus.pos_ply1, 10'd200);
        check("reset_p2", bus.pos_ply2, 10'd200);
        rst = 1'b0;
        cyc(2);

        for (int i = 0; i < 11; i++) begin
            set_btn(vecs[i].btn);
            for (int t = 0; t < vecs[i].ticks; t++) frame();
            check({vecs[i].name, "_p1"}, bus.pos_ply1, vecs[i].e1);
            check({vecs[i].name, "_p2"}, bus.pos_ply2, vecs[i].e2);
        end

        // 5-cycle glitch on up2 must be rejected; a held press is accepted
        set_btn(4'b0000);
        do_reset();
        bus.btn_up2 = 1'b1;
        cyc(5);
        bus.btn_up2 = 1'b0;
        cyc(14);
        frame();
        frame();
        check("glitch_no_move_p2", bus.pos_ply2, 10'd200);
        set_btn(4'b0100);
        frame();
        check("held_up2_tick1", bus.pos_ply2, 10'd198);
        frame();
        check("held_up2_tick2", bus.pos_ply2, 10'd196);

        // Upper clamp: 8 slow + 30 fast reaches 4, next push clamps to 0
        set_btn(4'b0000);
        do_reset();
        set_btn(4'b0001);
        for (int t = 0; t < 38; t++) frame();
        check("up1_near_top", bus.pos_ply1, 10'd4);
        frame();
        check("up1_clamp_0", bus.pos_ply1, 10'd0);
        frame();
        check("up1_stay_0", bus.pos_ply1, 10'd0);

        // Lower clamp on both players at once
        set_btn(4'b0000);
        do_reset();
        set_btn(4'b1010);
        for (int t = 0; t < 41; t++) frame();
        check("dn_near_max_p1", bus.pos_ply1, 10'd414);
        check("dn_near_max_p2", bus.pos_ply2, 10'd414);
        frame();
        check("dn_at_max_p1", bus.pos_ply1, 10'd420);
        frame();
        check("dn_sat_max_p1", bus.pos_ply1, 10'd420);
        check("dn_sat_max_p2", bus.pos_ply2, 10'd420);

        // Reset mid-frame takes effect before the next clock edge
        bus.vsync = 1'b1;
        cyc(1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_p1", bus.pos_ply1, 10'd200);
        check("async_reset_p2", bus.pos_ply2, 10'd200);
        bus.vsync = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
